// File: rtl/ppu_render_scheduler_pkg.sv
// Shared PPU definitions: render scheduler state encoding, screen geometry
// defaults and the tile width used to step across a scanline.
package ppu_render_scheduler_pkg;

  localparam int NUM_ROWS_DEFAULT = 240;
  localparam int NUM_COLS_DEFAULT = 256;
  localparam int TILE_W           = 8;
  localparam int POS_W            = 9;
  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 8;

  // Bit positions inside the PPU mask register.
  localparam int BG_EN_BIT  = 3;
  localparam int SPR_EN_BIT = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPU_ACC = 3'd1,
    S_CPU_ACK = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5,
    S_ADVANCE = 3'd6
  } state_t;

  // A frame only needs tiles when at least one layer is being drawn.
  function automatic logic render_enabled(input logic [1:0] layer_en);
    return |layer_en;
  endfunction

endpackage

// File: rtl/ppu_render_scheduler_if.sv
// Bus bundle between the render scheduler, the tile load FSM, the CPU port
// and the shared VRAM port.
interface ppu_render_scheduler_if;
  import ppu_render_scheduler_pkg::*;

  // Handshakes: frame_start and fsm_start are single-cycle requests with no
  // back-pressure; fsm_busy rises after fsm_start and its fall marks the tile
  // done; cpu_req is a level held with stable cpu_we/addr/wdata until the
  // one-cycle cpu_ack, which also qualifies cpu_rdata.
  logic                frame_start;
  logic [7:0]          ppu_ctrl2;
  logic                fsm_start;
  logic                fsm_busy;
  logic [POS_W-1:0]    curr_row;
  logic [POS_W-1:0]    curr_col;
  logic [ADDR_W-1:0]   fsm_vram_addr;
  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_ack;
  logic [DATA_W-1:0]   cpu_rdata;
  logic [ADDR_W-1:0]   vram_addr;
  logic [DATA_W-1:0]   vram_wdata;
  logic                vram_we;
  logic [DATA_W-1:0]   vram_rdata;
  logic                vblank;
  logic                frame_done;
  logic                frame_overrun;

  modport slave (
    input  frame_start, ppu_ctrl2, fsm_busy, fsm_vram_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output fsm_start, curr_row, curr_col, cpu_ack, cpu_rdata,
    output vram_addr, vram_wdata, vram_we, vblank, frame_done, frame_overrun
  );

  modport master (
    output frame_start, ppu_ctrl2, fsm_busy, fsm_vram_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  fsm_start, curr_row, curr_col, cpu_ack, cpu_rdata,
    input  vram_addr, vram_wdata, vram_we, vblank, frame_done, frame_overrun
  );

endinterface

// File: rtl/ppu_vram_arbiter.sv
// Shared VRAM port steering between the CPU and the tile loader, plus the
// register that returns CPU read data.
module ppu_vram_arbiter
  import ppu_render_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_sel,
  input  logic              i_capture,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_fsm_vram_addr,
  input  logic [DATA_W-1:0] i_vram_rdata,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [DATA_W-1:0] o_vram_wdata,
  output logic              o_vram_we,
  output logic [DATA_W-1:0] o_cpu_rdata
);

  logic [DATA_W-1:0] r_cpu_rdata;

  // The CPU owns the port for exactly the grant cycle; write data is zeroed
  // otherwise so the bus is quiet while the tile loader is reading.
  always_comb begin
    o_vram_addr  = i_fsm_vram_addr;
    o_vram_wdata = '0;
    o_vram_we    = 1'b0;
    if (i_cpu_sel) begin
      o_vram_addr  = i_cpu_addr;
      o_vram_wdata = i_cpu_wdata;
      o_vram_we    = i_cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cpu_rdata <= '0;
    end else if (i_capture) begin
      r_cpu_rdata <= i_vram_rdata;
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;

endmodule

// File: rtl/ppu_render_scheduler.sv
// Frame render sequencer: walks 8-pixel tiles in raster order through the
// tile load FSM and interleaves CPU VRAM accesses while no frame is rendering.
module ppu_render_scheduler
  import ppu_render_scheduler_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
  parameter int NUM_COLS = NUM_COLS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  ppu_render_scheduler_if.slave bus,
  output state_t                o_dbg_state
);

  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(NUM_ROWS - 1);
  localparam logic [POS_W-1:0] LAST_COL = POS_W'(NUM_COLS - TILE_W);
  localparam logic [POS_W-1:0] COL_STEP = POS_W'(TILE_W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [POS_W-1:0] r_row;
  logic [POS_W-1:0] r_col;
  logic             r_vblank;
  logic             r_frame_done;
  logic             r_overrun;
  logic             r_pending;
  logic             r_cpu_ack;

  logic w_frame_req;
  logic w_last_row;
  logic w_last_col;
  logic w_in_cpu;
  logic w_rendering;
  logic w_fsm_start;
  logic w_cpu_sel;
  logic w_capture;
  logic w_accept_render;
  logic w_accept_empty;
  logic w_frame_end;

  assign w_frame_req = bus.frame_start | r_pending;
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_col  = (r_col == LAST_COL);
  assign w_in_cpu    = (r_state == S_CPU_ACC) || (r_state == S_CPU_ACK);
  assign w_rendering = (r_state == S_ISSUE) || (r_state == S_WAIT_HI) ||
                       (r_state == S_WAIT_LO) || (r_state == S_ADVANCE);

  always_comb begin
    w_state_nxt     = r_state;
    w_fsm_start     = 1'b0;
    w_cpu_sel       = 1'b0;
    w_capture       = 1'b0;
    w_accept_render = 1'b0;
    w_accept_empty  = 1'b0;
    w_frame_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A frame request beats the CPU; r_cpu_ack blocks a re-grant while the
        // requester is still dropping cpu_req after its acknowledge.
        if (w_frame_req) begin
          if (render_enabled(bus.ppu_ctrl2[SPR_EN_BIT:BG_EN_BIT])) begin
            w_accept_render = 1'b1;
            w_state_nxt     = S_ISSUE;
          end else begin
            w_accept_empty  = 1'b1;
          end
        end else if (bus.cpu_req && !r_cpu_ack) begin
          w_state_nxt = S_CPU_ACC;
        end
      end
      S_CPU_ACC: begin
        w_cpu_sel   = 1'b1;
        w_state_nxt = S_CPU_ACK;
      end
      S_CPU_ACK: begin
        w_capture   = !bus.cpu_we;
        w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        w_fsm_start = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.fsm_busy) w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.fsm_busy) w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (w_last_row && w_last_col) begin
          w_frame_end = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_vblank     <= 1'b1;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_pending    <= 1'b0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_accept_empty | w_frame_end;
      r_cpu_ack    <= (r_state == S_CPU_ACK);

      // Pending is consumed by IDLE in the same cycle it is evaluated there.
      if (bus.frame_start && w_in_cpu) begin
        r_pending <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end

      if (w_accept_render || w_accept_empty) begin
        r_overrun <= 1'b0;
      end else if (bus.frame_start && w_rendering) begin
        r_overrun <= 1'b1;
      end

      if (w_accept_render) begin
        r_vblank <= 1'b0;
      end else if (w_frame_end) begin
        r_vblank <= 1'b1;
      end

      if (w_accept_render) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_state == S_ADVANCE) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + COL_STEP;
        end
      end
    end
  end

  ppu_vram_arbiter u_arbiter (
    .clk             (clk),
    .rst             (rst),
    .i_cpu_sel       (w_cpu_sel),
    .i_capture       (w_capture),
    .i_cpu_addr      (bus.cpu_addr),
    .i_cpu_wdata     (bus.cpu_wdata),
    .i_cpu_we        (bus.cpu_we),
    .i_fsm_vram_addr (bus.fsm_vram_addr),
    .i_vram_rdata    (bus.vram_rdata),
    .o_vram_addr     (bus.vram_addr),
    .o_vram_wdata    (bus.vram_wdata),
    .o_vram_we       (bus.vram_we),
    .o_cpu_rdata     (bus.cpu_rdata)
  );

  assign bus.fsm_start     = w_fsm_start;
  assign bus.curr_row      = r_row;
  assign bus.curr_col      = r_col;
  assign bus.cpu_ack       = r_cpu_ack;
  assign bus.vblank        = r_vblank;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_overrun = r_overrun;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ppu_render_scheduler.sv
// Directed bench for ppu_render_scheduler: tile load FSM model, VRAM model,
// raster-order scoreboard and a linear sequence of checked steps.
module tb_ppu_render_scheduler;
  import ppu_render_scheduler_pkg::*;

  localparam int ROWS  = 240;
  localparam int COLS  = 256;
  localparam int TILES = ROWS * COLS / 8;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  always #5 clk = ~clk;

  ppu_render_scheduler_if bus ();

  ppu_render_scheduler #(.NUM_ROWS(ROWS), .NUM_COLS(COLS)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q[$];
  int          start_cnt  = 0;
  int          raster_err = 0;
  int          stab_err   = 0;
  int          we_err     = 0;
  int          done_cnt   = 0;
  int          ack_cnt    = 0;
  int          wr_cnt     = 0;
  logic [17:0] tile_pos   = '0;
  logic [15:0] wr_addr    = '0;
  logic [7:0]  wr_data    = '0;
  int          busy_hold  = 6;
  int          m_cnt      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Tile load FSM model: busy rises the cycle after fsm_start, held busy_hold cycles.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_cnt = 0;
      bus.fsm_busy = 1'b0;
    end else begin
      if (m_cnt != 0) begin
        bus.fsm_busy = 1'b1;
        m_cnt--;
      end else begin
        bus.fsm_busy = 1'b0;
      end
      if (bus.fsm_start) m_cnt = busy_hold;
    end
  end

  // VRAM model: data appears one cycle after the address.
  always @(posedge clk)
    bus.vram_rdata <= (bus.vram_addr == 16'h2000) ? 8'hA5 : (bus.vram_addr[7:0] ^ 8'h5A);

  // Scoreboard and bus monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fsm_start) begin
        start_cnt++;
        if (exp_q.size() == 0) raster_err++;
        else if ({bus.curr_row, bus.curr_col} !== exp_q.pop_front()) raster_err++;
        tile_pos = {bus.curr_row, bus.curr_col};
      end
      if ((dbg_state == S_WAIT_HI || dbg_state == S_WAIT_LO || dbg_state == S_ADVANCE) &&
          ({bus.curr_row, bus.curr_col} !== tile_pos)) stab_err++;
      if (bus.vram_we && !bus.vblank) we_err++;
      if (bus.frame_done) done_cnt++;
      if (bus.cpu_ack) ack_cnt++;
      if (bus.vram_we) begin
        wr_cnt++;
        wr_addr = bus.vram_addr;
        wr_data = bus.vram_wdata;
      end
    end
  end

  initial begin
    int cyc;
    int done_before;
    int ack_before;

    rst_n             = 1'b0;
    bus.frame_start   = 1'b0;
    bus.ppu_ctrl2     = 8'h00;
    bus.cpu_req       = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 16'h0000;
    bus.cpu_wdata     = 8'h00;
    bus.fsm_vram_addr = 16'h1234;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_fsm_start", 32'(bus.fsm_start), 32'h0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    chk("rst_vram_we", 32'(bus.vram_we), 32'h0);
    chk("rst_vram_wdata", 32'(bus.vram_wdata), 32'h0);
    chk("rst_vram_addr", 32'(bus.vram_addr), 32'h1234);
    chk("rst_curr_row", 32'(bus.curr_row), 32'h0);
    chk("rst_curr_col", 32'(bus.curr_col), 32'h0);
    chk("rst_vblank", 32'(bus.vblank), 32'h1);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst_overrun", 32'(bus.frame_overrun), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Frame with both layers disabled: immediate frame_done, no tiles.
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("empty_frame_done", 32'(bus.frame_done), 32'h1);
    chk("empty_fsm_start", 32'(bus.fsm_start), 32'h0);
    chk("empty_vblank", 32'(bus.vblank), 32'h1);
    chk("empty_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    chk("empty_done_pulse", 32'(bus.frame_done), 32'h0);
    #1;
    chk("empty_no_tiles", 32'(start_cnt), 32'h0);

    // CPU read of 0x2000 while idle.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h2000;
    @(negedge clk);
    chk("rd_grant_addr", 32'(bus.vram_addr), 32'h2000);
    chk("rd_grant_we", 32'(bus.vram_we), 32'h0);
    chk("rd_grant_noack", 32'(bus.cpu_ack), 32'h0);
    @(negedge clk);
    chk("rd_addr_released", 32'(bus.vram_addr), 32'h1234);
    chk("rd_ack_early", 32'(bus.cpu_ack), 32'h0);
    @(negedge clk);
    chk("rd_ack", 32'(bus.cpu_ack), 32'h1);
    chk("rd_data", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(bus.cpu_ack), 32'h0);
    chk("rd_data_held", 32'(bus.cpu_rdata), 32'hA5);
    chk("rd_no_regrant", 32'(dbg_state), 32'(S_IDLE));

    // Full frame with a concurrent CPU write and a mid-frame overrun.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c += 8)
        exp_q.push_back({9'(r), 9'(c)});
    bus.ppu_ctrl2   = 8'h18;
    bus.frame_start = 1'b1;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_addr    = 16'h3F00;
    bus.cpu_wdata   = 8'h0F;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("f1_vblank_low", 32'(bus.vblank), 32'h0);
    chk("f1_first_start", 32'(bus.fsm_start), 32'h1);
    chk("f1_first_pos", 32'({bus.curr_row, bus.curr_col}), 32'h0);
    chk("f1_cpu_blocked", 32'(bus.vram_we), 32'h0);

    cyc = 0;
    while (!(bus.fsm_start && bus.curr_row == 9'd100 && bus.curr_col == 9'd128) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk("f1_reach_100_128", 32'(bus.fsm_start), 32'h1);
    bus.frame_start = 1'b1;
    bus.ppu_ctrl2   = 8'h00;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("f1_overrun_set", 32'(bus.frame_overrun), 32'h1);
    chk("f1_still_render", 32'(bus.vblank), 32'h0);
    chk("f1_pos_held", 32'({bus.curr_row, bus.curr_col}), 32'({9'd100, 9'd128}));

    cyc = 0;
    while (!bus.frame_done && cyc < 50000) begin
      @(negedge clk);
      cyc++;
    end
    chk("f1_frame_done", 32'(bus.frame_done), 32'h1);
    chk("f1_vblank_high", 32'(bus.vblank), 32'h1);
    chk("f1_row_cleared", 32'(bus.curr_row), 32'h0);
    chk("f1_col_cleared", 32'(bus.curr_col), 32'h0);
    chk("f1_overrun_sticky", 32'(bus.frame_overrun), 32'h1);
    #1;
    chk("f1_tile_count", 32'(start_cnt), 32'(TILES));
    chk("f1_raster_order", 32'(raster_err), 32'h0);
    chk("f1_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("f1_pos_stable", 32'(stab_err), 32'h0);
    chk("f1_done_count", 32'(done_cnt), 32'h2);
    chk("f1_no_write_yet", 32'(wr_cnt), 32'h0);
    chk("f1_no_we_render", 32'(we_err), 32'h0);

    cyc = 0;
    while (!bus.cpu_ack && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("wr_ack", 32'(bus.cpu_ack), 32'h1);
    chk("wr_rdata_kept", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk("wr_count", 32'(wr_cnt), 32'h1);
    chk("wr_addr", 32'(wr_addr), 32'h3F00);
    chk("wr_data", 32'(wr_data), 32'h0F);
    chk("wr_ack_count", 32'(ack_cnt), 32'h2);

    // Second frame: overrun clears on acceptance, then reset in WAIT_LO at (50,64).
    busy_hold = 1;
    exp_q.delete();
    for (int r = 0; r <= 50; r++)
      for (int c = 0; c < COLS; c += 8)
        if (r < 50 || c <= 64) exp_q.push_back({9'(r), 9'(c)});
    @(negedge clk);
    bus.ppu_ctrl2   = 8'h08;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("f2_overrun_clr", 32'(bus.frame_overrun), 32'h0);
    chk("f2_vblank_low", 32'(bus.vblank), 32'h0);

    cyc = 0;
    while (!(dbg_state == S_WAIT_LO && bus.curr_row == 9'd50 && bus.curr_col == 9'd64) && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    chk("f2_reach_wait_lo", 32'({bus.curr_row, bus.curr_col}), 32'({9'd50, 9'd64}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("mid_rst_fsm_start", 32'(bus.fsm_start), 32'h0);
    chk("mid_rst_pos", 32'({bus.curr_row, bus.curr_col}), 32'h0);
    chk("mid_rst_vblank", 32'(bus.vblank), 32'h1);
    chk("mid_rst_done", 32'(bus.frame_done), 32'h0);
    chk("mid_rst_rdata", 32'(bus.cpu_rdata), 32'h0);
    chk("mid_rst_vram_we", 32'(bus.vram_we), 32'h0);
    #1;
    chk("f2_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("f2_raster_order", 32'(raster_err), 32'h0);
    done_before = done_cnt;
    ack_before  = ack_cnt;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt), 32'(done_before));

    // Restart after reset begins at (0,0).
    exp_q.push_back({9'd0, 9'd0});
    exp_q.push_back({9'd0, 9'd8});
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("restart_start", 32'(bus.fsm_start), 32'h1);
    chk("restart_pos", 32'({bus.curr_row, bus.curr_col}), 32'h0);
    cyc = 0;
    while (!(bus.fsm_start && bus.curr_col == 9'd8) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("restart_second_tile", 32'(exp_q.size()), 32'h0);
    chk("restart_raster", 32'(raster_err), 32'h0);

    // Reset in the middle of a CPU read: no acknowledge may follow.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h2000;
    @(negedge clk);
    chk("cpu_rst_granted", 32'(dbg_state), 32'(S_CPU_ACC));
    rst_n       = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("cpu_rst_no_ack", 32'(ack_cnt), 32'(ack_before));
    chk("cpu_rst_rdata", 32'(bus.cpu_rdata), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
